// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift controller: walks one PLL output channel to an absolute
// target phase by the shortest path, one tap step at a time.
module pll_phase_ctrl #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned PHASE_W    = 13,
  parameter int unsigned PHASE_MOD  = 40,
  parameter int unsigned INIT_PHASE = 16,
  parameter int unsigned STEP_GAP   = 4
) (
  input  logic               clkin1,
  input  logic               pll_rst,
  input  logic               pll_lock,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_ch,
  input  logic [PHASE_W-1:0] req_phase,
  output logic [2:0]         phase_sel,
  output logic               phase_dir,
  output logic               phase_step_n,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic [2:0]         rd_ch,
  output logic [PHASE_W-1:0] rd_phase
);

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned DW     = PHASE_W + 1;
  localparam int unsigned GAP_W  = (STEP_GAP > 2) ? $clog2(STEP_GAP - 1) : 1;

  localparam logic [2:0]         NCH3     = 3'(NUM_CH);
  localparam logic [DW-1:0]      MOD_D    = DW'(PHASE_MOD);
  localparam logic [PHASE_W-1:0] MOD_P    = PHASE_W'(PHASE_MOD);
  localparam logic [PHASE_W-1:0] MOD_M1   = PHASE_W'(PHASE_MOD - 1);
  localparam logic [PHASE_W-1:0] HALF     = PHASE_W'(PHASE_MOD / 2);
  localparam logic [PHASE_W-1:0] INIT     = PHASE_W'(INIT_PHASE);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(STEP_GAP - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_STEP = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_lock_q;
  logic                 r_bad;
  logic [PHASE_W-1:0]   r_rem;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [PHASE_W-1:0]   r_phase [MAX_CH];
  logic [2:0]           r_sel;
  logic                 r_dir;
  logic                 r_step_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [PHASE_W-1:0]   r_rd;

  logic                 w_accept;
  logic                 w_abort;
  logic                 w_lock_fall;
  logic                 w_bad;
  logic [PHASE_W-1:0]   w_cur;
  logic [DW-1:0]        w_diff;
  logic [PHASE_W-1:0]   w_fwd;
  logic                 w_up;
  logic [PHASE_W-1:0]   w_steps;

  assign req_ready   = (r_state == S_IDLE) && pll_lock;
  assign w_accept    = req_valid && req_ready;
  assign w_abort     = (r_state != S_IDLE) && !pll_lock;
  assign w_lock_fall = r_lock_q && !pll_lock;

  // Direction and step count are resolved at acceptance so phase_dir is stable from CALC onward.
  assign w_bad   = (req_ch >= NCH3) || ({1'b0, req_phase} >= MOD_D);
  assign w_cur   = r_phase[req_ch];
  assign w_diff  = (req_phase >= w_cur) ? ({1'b0, req_phase} - {1'b0, w_cur})
                                        : ({1'b0, req_phase} + MOD_D - {1'b0, w_cur});
  assign w_fwd   = PHASE_W'(w_diff);
  assign w_up    = (w_fwd <= HALF);
  assign w_steps = w_up ? w_fwd : (MOD_P - w_fwd);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (r_bad)                    w_next = S_IDLE;
        else if (r_rem == '0)         w_next = S_DONE;
        else                          w_next = S_STEP;
      end
      S_STEP: w_next = S_GAP;
      S_GAP:  if (r_gap_cnt == GAP_LAST) w_next = (r_rem != '0) ? S_STEP : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Lock loss beats everything, including a pending step.
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      r_state   <= S_IDLE;
      r_lock_q  <= 1'b0;
      r_bad     <= 1'b0;
      r_rem     <= '0;
      r_gap_cnt <= '0;
      r_sel     <= '0;
      r_dir     <= 1'b0;
      r_step_n  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= '0;
      for (int i = 0; i < MAX_CH; i++) r_phase[i] <= INIT;
    end else begin
      r_state   <= w_next;
      r_lock_q  <= pll_lock;
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_step_n  <= (w_next != S_STEP);
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
      r_rd      <= (rd_ch < NCH3) ? r_phase[rd_ch] : '0;

      if (w_accept) begin
        r_sel <= req_ch;
        r_bad <= w_bad;
        r_rem <= w_steps;
        r_err <= 1'b0;
        if (!w_bad) r_dir <= w_up;
      end

      if (w_abort)                            r_err <= 1'b1;
      else if ((r_state == S_CALC) && r_bad)  r_err <= 1'b1;

      if (r_state == S_STEP) begin
        r_rem <= r_rem - PHASE_W'(1);
        if (r_dir)
          r_phase[r_sel] <= (r_phase[r_sel] == MOD_M1) ? '0 : r_phase[r_sel] + PHASE_W'(1);
        else
          r_phase[r_sel] <= (r_phase[r_sel] == '0) ? MOD_M1 : r_phase[r_sel] - PHASE_W'(1);
      end

      // The PLL restores its static phases on relock, so tracking restarts there.
      if (w_lock_fall) begin
        for (int i = 0; i < MAX_CH; i++) r_phase[i] <= INIT;
      end
    end
  end

  assign phase_sel    = r_sel;
  assign phase_dir    = r_dir;
  assign phase_step_n = r_step_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign rd_phase     = r_rd;

endmodule
